// File: rtl/jtag_tap_host.sv
// ============================================================================
// jtag_tap_host : JTAG host engine driving TCK/TMS/TDI and sampling TDO. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module jtag_tap_host #(
  parameter int MAXLEN = 32,
  parameter int LENW   = 6
) (
  input  logic              Clock,
  input  logic              TRST,
  input  logic              Start,
  input  logic [1:0]        Cmd,
  input  logic [LENW-1:0]   Len,
  input  logic [MAXLEN-1:0] DataIn,
  input  logic              TDO,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  output logic              Busy,
  output logic              Done,
  output logic [MAXLEN-1:0] DataOut
);

  localparam int              IDXW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [LENW-1:0] LEN_MAX = LENW'(MAXLEN);
  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

  localparam logic [1:0] CMD_RST = 2'b00;
  localparam logic [1:0] CMD_IR  = 2'b01;
  localparam logic [1:0] CMD_DR  = 2'b10;
  localparam logic [1:0] CMD_RUN = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_NAV   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_EXIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state, state_nx;
  logic              ph, ph_nx;
  logic [1:0]        cmd_q, cmd_nx;
  logic [5:0]        nav_pat, nav_pat_nx, ld_pat;
  logic [2:0]        nav_cnt, nav_cnt_nx, ld_cnt;
  logic [LENW-1:0]   remain, remain_nx, ld_len;
  logic [IDXW-1:0]   idx, idx_nx;
  logic [MAXLEN-1:0] sh, sh_nx;
  logic              exit2, exit2_nx;
  logic              tlr, tlr_nx;
  logic              tck_nx, tms_nx, tdi_nx;
  logic              accept, ld_scan, scan_q, scan_nx;

  function automatic logic [2:0] after_nav(input logic [1:0] c, input logic [LENW-1:0] l);
    if (c == CMD_IR || c == CMD_DR) return (l != '0) ? S_SHIFT : S_EXIT;
    else if (c == CMD_RUN && l != '0) return S_SHIFT;
    else return S_DONE;
  endfunction

  assign accept  = Start && (state == S_IDLE || state == S_DONE);
  assign ld_scan = (Cmd == CMD_IR) || (Cmd == CMD_DR);
  assign scan_q  = (cmd_q == CMD_IR) || (cmd_q == CMD_DR);
  assign scan_nx = (cmd_nx == CMD_IR) || (cmd_nx == CMD_DR);

  // Navigation TMS pattern, LSB first; an empty scan turns the Shift step into Capture->Exit1.
  always_comb begin : load_decode
    ld_len = (ld_scan && Len > LEN_MAX) ? LEN_MAX : Len;
    ld_pat = '0;
    ld_cnt = '0;
    case (Cmd)
      CMD_RST: begin ld_pat = 6'b011111;                        ld_cnt = 3'd6; end
      CMD_IR:  begin ld_pat = {2'b00, (ld_len == '0), 3'b011};  ld_cnt = 3'd4; end
      CMD_DR:  begin ld_pat = {3'b000, (ld_len == '0), 2'b01};  ld_cnt = 3'd3; end
      default: ;
    endcase
    if (tlr && Cmd != CMD_RST) begin
      ld_pat = {ld_pat[4:0], 1'b0};
      ld_cnt = ld_cnt + 3'd1;
    end
  end

  always_ff @(posedge Clock or negedge TRST) begin
    if (!TRST) begin
      state   <= S_IDLE;
      ph      <= 1'b0;
      cmd_q   <= '0;
      nav_pat <= '0;
      nav_cnt <= '0;
      remain  <= '0;
      idx     <= '0;
      sh      <= '0;
      exit2   <= 1'b0;
      tlr     <= 1'b1;
      TCK     <= 1'b0;
      TMS     <= 1'b1;
      TDI     <= 1'b0;
    end else begin
      state   <= state_nx;
      ph      <= ph_nx;
      cmd_q   <= cmd_nx;
      nav_pat <= nav_pat_nx;
      nav_cnt <= nav_cnt_nx;
      remain  <= remain_nx;
      idx     <= idx_nx;
      sh      <= sh_nx;
      exit2   <= exit2_nx;
      tlr     <= tlr_nx;
      TCK     <= tck_nx;
      TMS     <= tms_nx;
      TDI     <= tdi_nx;
    end
  end

  // TDO is captured on the edge that raises TCK, i.e. the end of phase L.
  always_ff @(posedge Clock or negedge TRST) begin
    if (!TRST)                                DataOut      <= '0;
    else if (accept)                          DataOut      <= '0;
    else if (state == S_SHIFT && !ph && scan_q) DataOut[idx] <= TDO;
  end

  always_comb begin : next_state
    state_nx   = state;
    ph_nx      = ph;
    cmd_nx     = cmd_q;
    nav_pat_nx = nav_pat;
    nav_cnt_nx = nav_cnt;
    remain_nx  = remain;
    idx_nx     = idx;
    sh_nx      = sh;
    exit2_nx   = exit2;
    tlr_nx     = tlr;
    case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (accept) begin
          cmd_nx     = Cmd;
          nav_pat_nx = ld_pat;
          nav_cnt_nx = ld_cnt;
          remain_nx  = ld_len;
          idx_nx     = '0;
          sh_nx      = DataIn;
          exit2_nx   = 1'b0;
          tlr_nx     = 1'b0;
          ph_nx      = 1'b0;
          state_nx   = (ld_cnt != 3'd0) ? S_NAV : after_nav(Cmd, ld_len);
        end
      end
      S_NAV, S_SHIFT, S_EXIT: begin
        ph_nx = ~ph;
        if (ph) begin
          case (state)
            S_NAV: begin
              nav_pat_nx = nav_pat >> 1;
              nav_cnt_nx = nav_cnt - 3'd1;
              if (nav_cnt == 3'd1) state_nx = after_nav(cmd_q, remain);
            end
            S_SHIFT: begin
              remain_nx = remain - LEN_ONE;
              idx_nx    = idx + IDXW'(1);
              sh_nx     = sh >> 1;
              if (remain == LEN_ONE) state_nx = scan_q ? S_EXIT : S_DONE;
            end
            default: begin
              exit2_nx = 1'b1;
              if (exit2) state_nx = S_DONE;
            end
          endcase
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pin values for the step that begins on the next edge; held otherwise.
  always_comb begin : out_decode
    tck_nx = 1'b0;
    tms_nx = TMS;
    tdi_nx = TDI;
    if (state_nx == S_NAV || state_nx == S_SHIFT || state_nx == S_EXIT) begin
      if (ph_nx) begin
        tck_nx = 1'b1;
      end else begin
        tdi_nx = 1'b0;
        case (state_nx)
          S_NAV:   tms_nx = nav_pat_nx[0];
          S_SHIFT: begin
            tms_nx = scan_nx && (remain_nx == LEN_ONE);
            tdi_nx = scan_nx & sh_nx[0];
          end
          default: tms_nx = ~exit2_nx;
        endcase
      end
    end
    Busy = (state == S_NAV) || (state == S_SHIFT) || (state == S_EXIT);
    Done = (state == S_DONE);
  end

endmodule

`default_nettype wire

// File: doc/jtag_tap_host.md
Name: jtag_tap_host

Overview:
- JTAG host/master engine: the driving end of the TAP interface whose target side holds the shift/update IR cells.
- Generates TCK, TMS and TDI and samples TDO, so the design can run complete instruction and data scans against an on-chip or off-chip TAP.
- Accepts one command at a time from a local controller and reports captured TDO bits when the scan finishes.
- TAP is always left in Run-Test/Idle (RTI) between commands.

Parameters:
- MAXLEN, 32, maximum scan length in bits.
- LENW, 6, width of the Len port; must hold the value MAXLEN.

Ports:
- Clock  in  1  system clock; all state is on its rising edge.
- TRST  in  1  asynchronous active-low reset.
- Start  in  1  command strobe; accepted only when Busy=0.
- Cmd  in  2  command: 00 = TAP reset, 01 = IR scan, 10 = DR scan, 11 = idle for Len TCKs.
- Len  in  LENW  scan length / idle count; sampled with Start.
- DataIn  in  MAXLEN  bits to shift; bit 0 is shifted first. Sampled with Start.
- TDO  in  1  serial data from the target.
- TCK  out  1  test clock, Clock/2.
- TMS  out  1  test mode select.
- TDI  out  1  serial data to the target.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-Clock pulse when a command completes.
- DataOut  out  MAXLEN  captured TDO bits; bit i is the bit sampled on the i-th shift TCK. Bits at and above Len are 0.

Behaviour:
- Reset (TRST=0, async): TCK=0, TMS=1, TDI=0, Busy=0, Done=0, DataOut=0, FSM=IDLE.
  - The host's model of the target TAP state is set to Test-Logic-Reset (TLR).
  - The first command after reset that is not a TAP reset first emits one TMS=0 TCK (TLR to RTI).
- TCK timing: every TCK period is two Clock cycles.
  - Phase L: TCK=0; TMS and TDI are updated at the start of this phase.
  - Phase H: TCK=1.
  - TDO is sampled on the Clock edge that drives TCK from 0 to 1.
  - While idle, TCK stays 0 and TMS/TDI hold their last values.
- Command acceptance: Start while Busy=0 latches Cmd, Len and DataIn, and Busy goes to 1 on the next cycle. Start while Busy=1 is ignored.
- FSM states: IDLE, NAV, SHIFT, EXIT, DONE. Each NAV step is one TCK with a table-driven TMS value.
  - Cmd 00: TMS = 1,1,1,1,1,0 (6 TCKs), ending in RTI. TDI=0.
  - Cmd 01 (IR scan): NAV TMS = 1,1,0,0 (SelectDR, SelectIR, CaptureIR, ShiftIR).
    - Then SHIFT for Len TCKs. TDI=DataIn[i]; TMS=0, except the last shift TCK has TMS=1 (to Exit1).
    - Then EXIT TMS = 1,0 (UpdateIR, RTI).
  - Cmd 10 (DR scan): same as Cmd 01, but the NAV prefix is 1,0,0.
  - Cmd 11: Len TCKs with TMS=0, TDI=0. Len=0 completes with no TCK.
  - DONE: Done=1 for one cycle, Busy=0 in the same cycle, and DataOut is valid and stable until the next accepted Start.
- Len=0 on a scan: the ShiftIR/ShiftDR NAV step is replaced by TMS=1 (Capture to Exit1). The scan then runs EXIT as normal with no shift TCKs, and DataOut=0.
- Len > MAXLEN on a scan is clamped to MAXLEN.
- Captured data is written bit-indexed (DataOut[i] <= TDO on shift i). Stale bits are cleared when the command is accepted.
- TRST asserted mid-command: the command is aborted immediately with no Done pulse, and all outputs go to their reset values.
- Simultaneous Done and Start: Start is accepted (Busy is 0 in the DONE cycle).

Test Plan:
- TRST low, then high; Cmd=00 Start → TMS over 6 TCKs = 1,1,1,1,1,0; one Done pulse; Busy high for 12 Clocks plus overhead; TCK period is 2 Clocks.
- After reset, Cmd=01, Len=2, DataIn=2'b10, with TDO looped back to TDI through one TCK-rising flop → TMS = 0 (TLR→RTI), 1,1,0,0,0,1,1,0; TDI during shift = 0 then 1; DataOut[1:0] matches the target model.
- Cmd=10, Len=32, DataIn=32'hA5C3_0F81 into a 32-bit behavioural DR holding 32'h1234_5678 → DataOut=32'h1234_5678; the DR holds 32'hA5C3_0F81 after UpdateDR.
- Cmd=01, Len=0 → TMS = 1,1,0,1,1,0; no TDO sampled; DataOut=0; Done pulses.
- Start pulsed again while Busy → ignored; the TMS stream is unchanged; exactly one Done.
- TRST asserted during the SHIFT of a Len=16 DR scan → TCK=0, TMS=1, Busy=0 immediately, no Done; the next Cmd=11 begins with a TLR→RTI TMS=0 TCK.
